// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, branch flushes,
// whole-pipe freeze on data-memory wait, and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [2:0]       ID_ValidReg,
  input  logic [4:0]       EX_rd,
  input  logic [2:0]       EX_ValidReg,
  input  logic             EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  input  logic             stall_cnt_clr,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             EX_MEM_en,
  output logic             MEM_WB_bubble,
  output logic             dmem_req,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned LW = $clog2(LOAD_LAT + 1);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

  state_e           state_q, state_d;
  logic             ret_lu_q, ret_lu_d;
  logic [LW-1:0]    lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_acc, mem_stall, load_use;
  logic freeze, run_rules, lu_rules;
  logic pc_en_int;
  logic unused_valid_bits;

  assign unused_valid_bits = ^{ID_ValidReg[0], EX_ValidReg[2:1]};

  assign mem_acc   = MEM_MemRead | MEM_MemWrite;
  assign mem_stall = mem_acc & ~dmem_ready;
  assign load_use  = EX_MemRead & EX_ValidReg[0] & (EX_rd != 5'd0) &
                     ((ID_ValidReg[1] & (ID_rs1 == EX_rd)) |
                      (ID_ValidReg[2] & (ID_rs2 == EX_rd)));

  always_comb begin
    state_d       = state_q;
    ret_lu_d      = ret_lu_q;
    lu_cnt_d      = lu_cnt_q;
    freeze        = 1'b0;
    run_rules     = 1'b0;
    lu_rules      = 1'b0;
    pc_en_int     = 1'b1;
    IF_ID_en      = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_en      = 1'b1;
    ID_EX_flush   = 1'b0;
    EX_MEM_en     = 1'b1;
    MEM_WB_bubble = 1'b0;
    dmem_req      = mem_acc;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          freeze   = 1'b1;
          ret_lu_d = 1'b0;
          state_d  = MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      LU_STALL: begin
        if (mem_stall) begin
          freeze   = 1'b1;
          ret_lu_d = 1'b1;
          state_d  = MEM_WAIT;
        end else begin
          lu_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        // On completion the upstream stages resume exactly as the interrupted state would.
        if (!dmem_ready) freeze = 1'b1;
        else if (ret_lu_q) lu_rules = 1'b1;
        else run_rules = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      pc_en_int     = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_en      = 1'b0;
      EX_MEM_en     = 1'b0;
      MEM_WB_bubble = 1'b1;
    end

    if (run_rules) begin
      state_d = RUN;
      if (EX_branch_taken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (load_use) begin
        pc_en_int   = 1'b0;
        IF_ID_en    = 1'b0;
        ID_EX_flush = 1'b1;
        lu_cnt_d    = LW'(LOAD_LAT - 1);
        if (LOAD_LAT > 1) state_d = LU_STALL;
      end
    end

    if (lu_rules) begin
      pc_en_int   = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
      lu_cnt_d    = lu_cnt_q - LW'(1);
      state_d     = (lu_cnt_q == LW'(1)) ? RUN : LU_STALL;
    end

    if (stall_cnt_clr) stall_cnt_d = '0;
    else if (!pc_en_int && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    else stall_cnt_d = stall_cnt_q;

    pc_en = pc_en_int;
    if (!rst_n) begin
      pc_en         = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_en      = 1'b0;
      EX_MEM_en     = 1'b0;
      IF_ID_flush   = 1'b1;
      ID_EX_flush   = 1'b1;
      MEM_WB_bubble = 1'b1;
      dmem_req      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_lu_q    <= 1'b0;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_lu_q    <= ret_lu_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: LOAD_LAT=1/CNT_W=16 and LOAD_LAT=2/CNT_W=3
// instances driven together and compared against a bubble-counter reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic [2:0] ID_ValidReg, EX_ValidReg;
  logic EX_MemRead, EX_branch_taken, MEM_MemRead, MEM_MemWrite, dmem_ready, stall_cnt_clr;

  logic pc_en [2], IF_ID_en [2], IF_ID_flush [2], ID_EX_en [2], ID_EX_flush [2];
  logic EX_MEM_en [2], MEM_WB_bubble [2], dmem_req [2];
  logic [15:0] sc0;
  logic [2:0]  sc1;

  int checks = 0;
  int failures = 0;

  // Model state: remaining load-use bubbles, waiting-on-memory flag, stall count.
  int lat [2]   = '{1, 2};
  int smax [2]  = '{65535, 7};
  int lu_left [2];
  bit in_wait [2];
  int scnt [2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg),
    .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg), .EX_MemRead(EX_MemRead),
    .EX_branch_taken(EX_branch_taken), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .dmem_ready(dmem_ready), .stall_cnt_clr(stall_cnt_clr),
    .pc_en(pc_en[0]), .IF_ID_en(IF_ID_en[0]), .IF_ID_flush(IF_ID_flush[0]),
    .ID_EX_en(ID_EX_en[0]), .ID_EX_flush(ID_EX_flush[0]), .EX_MEM_en(EX_MEM_en[0]),
    .MEM_WB_bubble(MEM_WB_bubble[0]), .dmem_req(dmem_req[0]), .stall_cnt(sc0));

  pipeline_hazard_ctrl #(.LOAD_LAT(2), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg),
    .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg), .EX_MemRead(EX_MemRead),
    .EX_branch_taken(EX_branch_taken), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .dmem_ready(dmem_ready), .stall_cnt_clr(stall_cnt_clr),
    .pc_en(pc_en[1]), .IF_ID_en(IF_ID_en[1]), .IF_ID_flush(IF_ID_flush[1]),
    .ID_EX_en(ID_EX_en[1]), .ID_EX_flush(ID_EX_flush[1]), .EX_MEM_en(EX_MEM_en[1]),
    .MEM_WB_bubble(MEM_WB_bubble[1]), .dmem_req(dmem_req[1]), .stall_cnt(sc1));

  function automatic logic [7:0] obs_out(input int k);
    return {pc_en[k], IF_ID_en[k], IF_ID_flush[k], ID_EX_en[k], ID_EX_flush[k],
            EX_MEM_en[k], MEM_WB_bubble[k], dmem_req[k]};
  endfunction

  function automatic int obs_cnt(input int k);
    return (k == 0) ? int'(sc0) : int'(sc1);
  endfunction

  // Bit order: pc_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_bubble, dmem_req
  function automatic void eval(input int k, output logic [7:0] o, output int nl, output bit nw);
    bit acc, lu;
    acc = MEM_MemRead | MEM_MemWrite;
    lu  = EX_MemRead && EX_ValidReg[0] && EX_rd != 0 &&
          ((ID_ValidReg[1] && ID_rs1 == EX_rd) || (ID_ValidReg[2] && ID_rs2 == EX_rd));
    nl = lu_left[k];
    nw = 1'b0;
    o  = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, acc};
    if (!rst_n) begin
      o  = 8'b0010_1010;
      nl = 0;
    end else if ((in_wait[k] || acc) && !dmem_ready) begin
      o[7] = 1'b0; o[6] = 1'b0; o[4] = 1'b0; o[2] = 1'b0; o[1] = 1'b1;
      nw = 1'b1;
    end else if (lu_left[k] > 0) begin
      o[7] = 1'b0; o[6] = 1'b0; o[3] = 1'b1;
      nl = lu_left[k] - 1;
    end else if (EX_branch_taken) begin
      o[5] = 1'b1; o[3] = 1'b1;
    end else if (lu) begin
      o[7] = 1'b0; o[6] = 1'b0; o[3] = 1'b1;
      nl = lat[k] - 1;
    end
  endfunction

  task automatic chk(input string tag, input int k, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // Inputs are driven just after a negedge; outputs sampled 2 units later, state committed at posedge.
  task automatic cycle(input string tag);
    logic [7:0] e [2];
    int nl [2];
    bit nw [2];
    #2;
    for (int k = 0; k < 2; k++) begin
      eval(k, e[k], nl[k], nw[k]);
      chk({tag, "_out"}, k, int'(obs_out(k)), int'(e[k]));
      chk({tag, "_cnt"}, k, obs_cnt(k), scnt[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst_n) begin
        lu_left[k] = nl[k];
        in_wait[k] = nw[k];
        if (stall_cnt_clr) scnt[k] = 0;
        else if (!e[k][7] && scnt[k] < smax[k]) scnt[k] = scnt[k] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lu_left[k] = 0;
      in_wait[k] = 1'b0;
      scnt[k]    = 0;
    end
  endtask

  task automatic idle();
    ID_rs1 = 5'd1; ID_rs2 = 5'd2; ID_ValidReg = 3'b111;
    EX_rd = 5'd3; EX_ValidReg = 3'b001; EX_MemRead = 1'b0; EX_branch_taken = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; dmem_ready = 1'b0; stall_cnt_clr = 1'b0;
  endtask

  initial begin
    int cnt_before;
    bit acc;
    model_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    cycle("reset");
    rst_n = 1'b1;
    cycle("idle");

    // Load-use on rs1 (lw x5; add x6,x5,x1), then the bubble reaches EX.
    EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_rs2 = 5'd1;
    cycle("lu_rs1");
    EX_MemRead = 1'b0; EX_ValidReg = 3'b000;
    cycle("lu_after");
    chk("lu_cnt1", 0, int'(sc0), 1);
    cycle("lu_drain");

    // No stall: rd=x0, or matching numbers on unused sources.
    idle(); EX_MemRead = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0;
    cycle("lu_x0");
    EX_rd = 5'd7; ID_rs1 = 5'd7; ID_rs2 = 5'd7; ID_ValidReg = 3'b001;
    cycle("lu_unused");
    ID_ValidReg = 3'b101; ID_rs1 = 5'd2;
    cycle("lu_rs2");
    idle();
    cycle("idle2");
    cycle("idle3");

    // Branch wins over load-use.
    EX_MemRead = 1'b1; EX_rd = 5'd4; ID_rs1 = 5'd4; EX_branch_taken = 1'b1;
    cycle("br_lu");
    idle();
    cycle("br_after");

    // Store waiting three cycles.
    stall_cnt_clr = 1'b1;
    cycle("clr");
    stall_cnt_clr = 1'b0;
    MEM_MemWrite = 1'b1;
    for (int i = 0; i < 3; i++) cycle("sw_wait");
    dmem_ready = 1'b1;
    cycle("sw_done");
    idle();
    cycle("sw_after");
    chk("sw_cnt3", 0, int'(sc0), 3);

    // Load-use then a two-cycle memory stall during the bubble.
    EX_MemRead = 1'b1; EX_rd = 5'd9; ID_rs1 = 5'd9;
    cycle("lu2_start");
    EX_MemRead = 1'b0; EX_ValidReg = 3'b000; MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    cycle("lu2_ms1");
    cycle("lu2_ms2");
    dmem_ready = 1'b1;
    cycle("lu2_rdy");
    idle();
    cycle("lu2_after");

    // Zero-wait access.
    MEM_MemRead = 1'b1; dmem_ready = 1'b1;
    cycle("zero_wait");

    // Reset asserted mid-MEM_WAIT.
    idle(); MEM_MemWrite = 1'b1;
    cycle("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out", k, int'(obs_out(k)), 8'h2A);
      chk("rst_cnt", k, obs_cnt(k), 0);
    end
    model_reset();
    idle();
    @(negedge clk);
    cycle("in_rst");
    rst_n = 1'b1;
    cycle("post_rst");

    // Randomized traffic; a pending memory access is held until it completes.
    for (int n = 0; n < 3000; n++) begin
      ID_rs1 = 5'($urandom_range(0, 3));
      ID_rs2 = 5'($urandom_range(0, 3));
      EX_rd  = 5'($urandom_range(0, 3));
      ID_ValidReg = 3'($urandom);
      EX_ValidReg = 3'($urandom);
      EX_MemRead = 1'($urandom_range(0, 1));
      EX_branch_taken = ($urandom_range(0, 7) == 0);
      if (!in_wait[0]) begin
        acc = ($urandom_range(0, 3) == 0);
        MEM_MemRead  = acc & 1'($urandom);
        MEM_MemWrite = acc & ~MEM_MemRead;
      end
      dmem_ready = 1'($urandom);
      stall_cnt_clr = ($urandom_range(0, 39) == 0);
      cycle("rand");
    end

    cnt_before = checks;
    if (cnt_before < 12) failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
